// File: rtl/topk_max_heap.sv
// Top-K tracker: a binary max-heap of {count, address} keyed by count.
// An accepted input either updates a matching entry, fills the next free node,
// or replaces the smallest leaf. The touched node is then sifted up, one level
// per cycle.
module topk_max_heap #(
  parameter int unsigned CNT_SIZE    = 20,
  parameter int unsigned ADDR_SIZE   = 28,
  parameter int unsigned TOTAL_LEVEL = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 input_valid,
  input  logic [CNT_SIZE-1:0]  input_cnt,
  input  logic [ADDR_SIZE-1:0] input_addr,
  input  logic                 input_query,
  output logic                 ready,
  output logic                 query_valid,
  output logic [CNT_SIZE-1:0]  query_cnt,
  output logic [ADDR_SIZE-1:0] query_addr
);

  localparam int unsigned K       = (1 << TOTAL_LEVEL) - 1;
  localparam int unsigned LEAF_LO = 1 << (TOTAL_LEVEL - 1);
  localparam int unsigned IW      = TOTAL_LEVEL;

  typedef enum logic [0:0] {StIdle, StSift} state_e;

  logic                 occ  [1:K];
  logic [CNT_SIZE-1:0]  cnt  [1:K];
  logic [ADDR_SIZE-1:0] addr [1:K];

  // Bench-visible view of the heap; empty nodes read as 0/0
  logic [CNT_SIZE-1:0]  cnt_wire  [1:K];
  logic [ADDR_SIZE-1:0] addr_wire [1:K];

  state_e               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [IW-1:0]        par_idx;

  logic                 match_found;
  logic [IW-1:0]        match_idx;
  logic [IW-1:0]        free_idx;
  logic                 full;
  logic [IW-1:0]        min_idx;
  logic [CNT_SIZE-1:0]  min_cnt;

  logic                 wr_en;
  logic [IW-1:0]        wr_idx;
  logic                 swap_en;

  // Gate node contents with occupancy for the visible arrays
  always_comb begin
    for (int i = 1; i <= int'(K); i++) begin
      cnt_wire[i]  = occ[i] ? cnt[i]  : '0;
      addr_wire[i] = occ[i] ? addr[i] : '0;
    end
  end

  // Parallel searches: address match, first free node, minimum-count leaf
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    free_idx    = '0;
    // Downward scan so the lowest index wins
    for (int i = int'(K); i >= 1; i--) begin
      if (occ[i] && (addr[i] == input_addr)) begin
        match_found = 1'b1;
        match_idx   = IW'(i);
      end
      if (!occ[i]) free_idx = IW'(i);
    end
    full    = occ[K];
    min_idx = IW'(LEAF_LO);
    min_cnt = cnt[LEAF_LO];
    // Strict less-than keeps the lowest index on ties
    for (int i = int'(LEAF_LO) + 1; i <= int'(K); i++) begin
      if (cnt[i] < min_cnt) begin
        min_cnt = cnt[i];
        min_idx = IW'(i);
      end
    end
  end

  // State and sift position register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state: choose the write target on accept, then walk toward the root
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_en   = 1'b0;
    wr_idx  = '0;
    swap_en = 1'b0;
    par_idx = idx_q >> 1;
    unique case (state_q)
      StIdle: begin
        if (input_valid) begin
          if (match_found) begin
            if (input_cnt > cnt[match_idx]) begin
              wr_en  = 1'b1;
              wr_idx = match_idx;
            end
          end else if (!full) begin
            wr_en  = 1'b1;
            wr_idx = free_idx;
          end else if (input_cnt > min_cnt) begin
            wr_en  = 1'b1;
            wr_idx = min_idx;
          end
          if (wr_en) begin
            state_d = StSift;
            idx_d   = wr_idx;
          end
        end
      end
      StSift: begin
        // Equal counts stay put so earlier entries keep the higher slot
        if ((idx_q != IW'(1)) && (cnt[idx_q] > cnt[par_idx])) begin
          swap_en = 1'b1;
          idx_d   = par_idx;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    ready = (state_q == StIdle);
  end

  // Node storage: accept-time write or one sift-up swap per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i <= int'(K); i++) begin
        occ[i]  <= 1'b0;
        cnt[i]  <= '0;
        addr[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        occ[wr_idx]  <= 1'b1;
        cnt[wr_idx]  <= input_cnt;
        addr[wr_idx] <= input_addr;
      end
      if (swap_en) begin
        cnt[idx_q]    <= cnt[par_idx];
        cnt[par_idx]  <= cnt[idx_q];
        addr[idx_q]   <= addr[par_idx];
        addr[par_idx] <= addr[idx_q];
      end
    end
  end

  // Root snapshot, independent of the operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      query_valid <= 1'b0;
      query_cnt   <= '0;
      query_addr  <= '0;
    end else begin
      query_valid <= input_query;
      if (input_query) begin
        query_cnt  <= cnt_wire[1];
        query_addr <= addr_wire[1];
      end
    end
  end

endmodule

// File: tb/tb_topk_max_heap.sv
// Bench for topk_max_heap: table of small insert/update cases, fill and
// eviction sequences, ignored-while-busy input, queries via a scoreboard,
// and reset in the middle of a sift.
module tb_topk_max_heap;

  localparam int CW = 20;
  localparam int AW = 28;
  localparam int K  = 63;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          input_valid = 1'b0;
  logic [CW-1:0] input_cnt = '0;
  logic [AW-1:0] input_addr = '0;
  logic          input_query = 1'b0;
  logic          ready;
  logic          query_valid;
  logic [CW-1:0] query_cnt;
  logic [AW-1:0] query_addr;

  topk_max_heap #(.CNT_SIZE(CW), .ADDR_SIZE(AW), .TOTAL_LEVEL(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .input_valid(input_valid),
    .input_cnt  (input_cnt),
    .input_addr (input_addr),
    .input_query(input_query),
    .ready      (ready),
    .query_valid(query_valid),
    .query_cnt  (query_cnt),
    .query_addr (query_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] c;
    logic [AW-1:0] a;
  } pair_t;

  typedef struct {
    logic [CW-1:0] c;
    logic [AW-1:0] a;
    bit            q;
    pair_t         qexp;
    pair_t         n1;
    pair_t         n2;
    pair_t         n3;
  } vec_t;

  pair_t sb[$];
  int    errors = 0;
  int    checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sum_cnt();
    int s = 0;
    for (int i = 1; i <= K; i++) s += int'(dut.cnt_wire[i]);
    return s;
  endfunction

  function automatic int sum_addr();
    int s = 0;
    for (int i = 1; i <= K; i++) s += int'(dut.addr_wire[i]);
    return s;
  endfunction

  function automatic int count_addr(input logic [AW-1:0] a);
    int n = 0;
    for (int i = 1; i <= K; i++) if (dut.addr_wire[i] == a && dut.cnt_wire[i] != 0) n++;
    return n;
  endfunction

  function automatic int heap_violations();
    int n = 0;
    for (int i = 2; i <= K; i++) if (dut.cnt_wire[i/2] < dut.cnt_wire[i]) n++;
    return n;
  endfunction

  // Scoreboard consumer: every query response must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && query_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL query_unexpected: got cnt %0h addr %0h expected no response",
                 query_cnt, query_addr);
      end else begin
        pair_t e;
        e = sb.pop_front();
        chk("query_cnt", 64'(query_cnt), 64'(e.c));
        chk("query_addr", 64'(query_addr), 64'(e.a));
      end
    end
  end

  // Strobe one input (optionally with a query) and wait for the heap to settle
  task automatic send(input logic [CW-1:0] c, input logic [AW-1:0] a, input bit q,
                      input pair_t qexp);
    int n;
    n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_send", 64'(ready), 64'd1);
    input_valid = 1'b1;
    input_cnt   = c;
    input_addr  = a;
    if (q) begin
      input_query = 1'b1;
      sb.push_back(qexp);
    end
    @(negedge clk);
    input_valid = 1'b0;
    input_query = 1'b0;
    n = 1;
    while (!ready && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk("settle_within_7", 64'(n <= 7), 64'd1);
  endtask

  task automatic query(input pair_t e);
    input_query = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    input_query = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  tbl[7];
    pair_t none;
    int    n;
    none = '{c: '0, a: '0};

    // {cnt, addr, query?, expected query, node1, node2, node3}
    tbl[0] = '{c: 5,  a: 'hA, q: 0, qexp: none,             n1: '{5, 'hA},  n2: '{0, 0},   n3: '{0, 0}};
    tbl[1] = '{c: 9,  a: 'hB, q: 0, qexp: none,             n1: '{9, 'hB},  n2: '{5, 'hA}, n3: '{0, 0}};
    tbl[2] = '{c: 3,  a: 'hC, q: 0, qexp: none,             n1: '{9, 'hB},  n2: '{5, 'hA}, n3: '{3, 'hC}};
    tbl[3] = '{c: 12, a: 'hA, q: 1, qexp: '{c: 9, a: 'hB},  n1: '{12, 'hA}, n2: '{9, 'hB}, n3: '{3, 'hC}};
    tbl[4] = '{c: 4,  a: 'hA, q: 0, qexp: none,             n1: '{12, 'hA}, n2: '{9, 'hB}, n3: '{3, 'hC}};
    tbl[5] = '{c: 9,  a: 'hB, q: 0, qexp: none,             n1: '{12, 'hA}, n2: '{9, 'hB}, n3: '{3, 'hC}};
    tbl[6] = '{c: 13, a: 'hC, q: 1, qexp: '{c: 12, a: 'hA}, n1: '{13, 'hC}, n2: '{9, 'hB}, n3: '{12, 'hA}};

    // Reset state
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_cnt_sum", 64'(sum_cnt()), 64'd0);
    chk("reset_addr_sum", 64'(sum_addr()), 64'd0);
    chk("reset_ready", 64'(ready), 64'd1);
    chk("reset_query_valid", 64'(query_valid), 64'd0);
    chk("reset_query_cnt", 64'(query_cnt), 64'd0);
    query('{c: 0, a: 0});

    // Table-driven insert/update cases
    for (int i = 0; i < 7; i++) begin
      send(tbl[i].c, tbl[i].a, tbl[i].q, tbl[i].qexp);
      repeat (12) @(negedge clk);
      chk("node1_cnt", 64'(dut.cnt_wire[1]), 64'(tbl[i].n1.c));
      chk("node1_addr", 64'(dut.addr_wire[1]), 64'(tbl[i].n1.a));
      chk("node2_cnt", 64'(dut.cnt_wire[2]), 64'(tbl[i].n2.c));
      chk("node2_addr", 64'(dut.addr_wire[2]), 64'(tbl[i].n2.a));
      chk("node3_cnt", 64'(dut.cnt_wire[3]), 64'(tbl[i].n3.c));
      chk("node3_addr", 64'(dut.addr_wire[3]), 64'(tbl[i].n3.a));
      chk("node4_empty", 64'(dut.cnt_wire[4]), 64'd0);
    end
    query('{c: 13, a: 'hC});

    // Fill with counts 1..63, each new entry sifting to the root
    do_reset();
    for (int i = 1; i <= K; i++) send(CW'(i), AW'(i), 1'b0, none);
    chk("full_root_cnt", 64'(dut.cnt_wire[1]), 64'd63);
    chk("full_root_addr", 64'(dut.addr_wire[1]), 64'd63);
    chk("full_invariant", 64'(heap_violations()), 64'd0);
    chk("full_cnt_sum", 64'(sum_cnt()), 64'd2016);

    // Eviction of the count-1 leaf, with an input pulsed while busy
    input_valid = 1'b1;
    input_cnt   = 100;
    input_addr  = 'h7F;
    @(negedge clk);
    input_cnt  = 200;
    input_addr = 'h90;
    chk("busy_after_evict", 64'(ready), 64'd0);
    @(negedge clk);
    input_valid = 1'b0;
    n = 0;
    while (!ready && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk("evict_settled", 64'(ready), 64'd1);
    chk("evict_root_cnt", 64'(dut.cnt_wire[1]), 64'd100);
    chk("evict_root_addr", 64'(dut.addr_wire[1]), 64'h7F);
    chk("evicted_addr1_gone", 64'(count_addr(1)), 64'd0);
    chk("busy_input_ignored", 64'(count_addr('h90)), 64'd0);
    chk("evict_cnt_sum", 64'(sum_cnt()), 64'd2115);
    chk("evict_invariant", 64'(heap_violations()), 64'd0);

    // Too small for a full heap: dropped
    send(0, 'h80, 1'b0, none);
    chk("drop_cnt_sum", 64'(sum_cnt()), 64'd2115);
    chk("drop_addr_absent", 64'(count_addr('h80)), 64'd0);
    chk("drop_root_cnt", 64'(dut.cnt_wire[1]), 64'd100);
    query('{c: 100, a: 'h7F});

    // Reset in the middle of a sift
    input_valid = 1'b1;
    input_cnt   = 150;
    input_addr  = 'h91;
    @(negedge clk);
    input_valid = 1'b0;
    @(negedge clk);
    chk("sift_in_progress", 64'(ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midsift_cnt_sum", 64'(sum_cnt()), 64'd0);
    chk("midsift_addr_sum", 64'(sum_addr()), 64'd0);
    chk("midsift_ready", 64'(ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(7, 'h5, 1'b0, none);
    chk("post_reset_root_cnt", 64'(dut.cnt_wire[1]), 64'd7);
    chk("post_reset_node2", 64'(dut.cnt_wire[2]), 64'd0);
    query('{c: 7, a: 'h5});

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/topk_max_heap.md
Name: topk_max_heap

Overview:
- Binary max-heap tracker of the top-K most frequent addresses, keyed by count; used behind a count-min sketch.
- Each valid input carries an address and its current estimated count. The block inserts, updates or drops the entry so the heap holds the highest-count addresses, with the largest at the root.
- Capacity is K = 2^TOTAL_LEVEL − 1 nodes, indexed 1..K. Node i has children 2i and 2i+1.

Parameters:
- CNT_SIZE, 20, count width in bits.
- ADDR_SIZE, 28, address width in bits.
- TOTAL_LEVEL, 6, number of heap levels; K = 2^TOTAL_LEVEL − 1 (63 by default).

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- input_valid  input  1  one-cycle strobe; input_cnt/input_addr are valid in that cycle.
- input_cnt  input  CNT_SIZE  count of input_addr.
- input_addr  input  ADDR_SIZE  address key.
- input_query  input  1  one-cycle root read request.
- ready  output  1  high when idle; an input is accepted only when ready=1.
- query_valid  output  1  one-cycle pulse, one cycle after an accepted input_query.
- query_cnt  output  CNT_SIZE  root count captured at query time.
- query_addr  output  ADDR_SIZE  root address captured at query time.

Behaviour:
- Storage:
  - Per node: occ bit, count, address.
  - Internal arrays cnt_wire[1..K] and addr_wire[1..K] continuously reflect node count/address and are hierarchically readable by benches.
  - Unoccupied nodes read 0/0.
- Reset: all occ=0, all counts/addresses 0, ready=1, query_valid=0, query_cnt=0, query_addr=0, operation state idle.
- Accept: input_valid while ready=1. input_valid while ready=0 is ignored (dropped) with no state change.
- Cycle 1 (accept edge):
  - Match all occupied nodes against input_addr in parallel.
  - Match at node m:
    - If input_cnt > cnt[m], write cnt[m]=input_cnt and start sift-up at m.
    - Otherwise no change; done, ready stays 1.
  - No match, heap not full: write {input_cnt, input_addr} into the lowest-index unoccupied node (occupancy is always contiguous 1..n), set occ, start sift-up there.
  - No match, heap full:
    - Find the minimum-count leaf among nodes 2^(TOTAL_LEVEL−1)..K; on a tie, take the lowest index.
    - If input_cnt > that count, overwrite the leaf and start sift-up.
    - Otherwise drop; done.
- Sift-up:
  - ready=0 while active.
  - Each cycle, compare node j with parent j/2.
  - If cnt[j] > cnt[j/2] (strictly), swap count and address, then continue at j/2.
  - Otherwise, or when j=1, finish and set ready=1 on the next cycle.
  - At most TOTAL_LEVEL−1 swap cycles. Worst-case accept-to-stable latency is TOTAL_LEVEL+1 cycles (7 at default).
- Invariant after each operation: for every occupied i>1, cnt[i/2] ≥ cnt[i]. Addresses are unique.
- Equal counts never swap, so the earlier-placed entry keeps the higher position.
- Query:
  - input_query is serviced in any state.
  - On the next edge, query_valid=1 and query_cnt/query_addr take the root value present at the request edge (0/0 if empty).
  - Read-only; the heap is not modified.
  - Simultaneous input_valid and input_query: the query returns the pre-insert root.
- Widths:
  - Counts compare unsigned and are never arithmetically modified.
  - Index arithmetic needs TOTAL_LEVEL bits.
- Reset asserted mid-operation clears everything immediately; the in-flight operation is lost.

Test Plan:
- Reset, then read cnt_wire[1..63] → all 0. ready=1, query_valid=0.
- Insert (5,0xA), (9,0xB), (3,0xC), 21 cycles apart → node1=(9,B), node2=(5,A), node3=(3,C). Each operation is stable ≤7 cycles after its strobe.
- Existing 0xA (node2, cnt 5), send (12,0xA) → node1=(12,A), node2=(9,B).
- Existing 0xA at cnt 12, send (4,0xA) → no change.
- Fill 63 distinct addresses with counts 1..63 in increasing order → root=63, heap invariant holds.
  - Then send (100,0x7F) → root=(100,0x7F), the count-1 entry is evicted.
  - Then send (0,0x80) → dropped.
- During a sift-up (ready=0), pulse input_valid → ignored.
- Pulse input_query with root (100,0x7F) → next cycle query_valid=1, query_cnt=100, query_addr=0x7F.
- Assert rst_n=0 mid-sift → all nodes read 0.
